// File: rtl/decoder_sched.sv
// Round-robin scheduler that shares one Hamming decoder between two requesters.
// Each job resets the decoder, waits for done under a watchdog, and returns a tagged response.
module decoder_sched #(
  parameter int unsigned TIMEOUT     = 32,
  parameter int unsigned DEC_RST_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [13:0] req0_rstring,
  input  logic [2:0]  req0_size,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [13:0] req1_rstring,
  input  logic [2:0]  req1_size,
  output logic        dec_rst,
  output logic [13:0] dec_rstring,
  output logic [2:0]  dec_size,
  input  logic [6:0]  dec_dstring,
  input  logic        dec_done,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [6:0]  resp_dstring,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned CW_W  = 14;
  localparam int unsigned SZ_W  = 3;
  localparam int unsigned DS_W  = 7;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dec_rst_q, dec_rst_d;
  logic [CW_W-1:0]   dec_rstring_q, dec_rstring_d;
  logic [SZ_W-1:0]   dec_size_q, dec_size_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_id_q, resp_id_d;
  logic [DS_W-1:0]   resp_dstring_q, resp_dstring_d;
  logic              resp_err_q, resp_err_d;
  logic              busy_q, busy_d;

  logic              any_valid_c;
  logic              grant_c;
  logic [CW_W-1:0]   sel_rstring_c;
  logic [SZ_W-1:0]   sel_size_c;

  // Round-robin grant: a lone requester always wins, a tie goes to the one not served last
  assign any_valid_c   = req0_valid | req1_valid;
  assign grant_c       = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign sel_rstring_c = grant_c ? req1_rstring : req0_rstring;
  assign sel_size_c    = grant_c ? req1_size : req0_size;

  assign req0_ready = ~rst & (state_q == IDLE) & any_valid_c & ~grant_c;
  assign req1_ready = ~rst & (state_q == IDLE) & any_valid_c & grant_c;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    cnt_d          = cnt_q;
    dec_rstring_d  = dec_rstring_q;
    dec_size_d     = dec_size_q;
    resp_id_d      = resp_id_q;
    resp_dstring_d = resp_dstring_q;
    resp_err_d     = resp_err_q;
    case (state_q)
      IDLE: begin
        if (any_valid_c) begin
          dec_rstring_d = sel_rstring_c;
          dec_size_d    = sel_size_c;
          resp_id_d     = grant_c;
          last_grant_d  = grant_c;
          cnt_d         = '0;
          // Size codes 4..7 are illegal: answer with an error without touching the decoder
          if (sel_size_c[2]) begin
            resp_err_d     = 1'b1;
            resp_dstring_d = '0;
            state_d        = RESP;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (cnt_q == CNT_W'(DEC_RST_CYC - 1)) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // done takes priority over a watchdog expiry in the same cycle
        if (dec_done) begin
          resp_dstring_d = dec_dstring;
          resp_err_d     = 1'b0;
          state_d        = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          resp_dstring_d = '0;
          resp_err_d     = 1'b1;
          state_d        = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    dec_rst_d    = (state_d == LOAD);
    resp_valid_d = (state_d == RESP);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      cnt_q          <= '0;
      dec_rst_q      <= 1'b1;
      dec_rstring_q  <= '0;
      dec_size_q     <= '0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= 1'b0;
      resp_dstring_q <= '0;
      resp_err_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
      dec_rst_q      <= dec_rst_d;
      dec_rstring_q  <= dec_rstring_d;
      dec_size_q     <= dec_size_d;
      resp_valid_q   <= resp_valid_d;
      resp_id_q      <= resp_id_d;
      resp_dstring_q <= resp_dstring_d;
      resp_err_q     <= resp_err_d;
      busy_q         <= busy_d;
    end
  end

  assign dec_rst      = dec_rst_q;
  assign dec_rstring  = dec_rstring_q;
  assign dec_size     = dec_size_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_dstring = resp_dstring_q;
  assign resp_err     = resp_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_decoder_sched.sv
// Self-checking bench for decoder_sched: vector table driven through a job task with a
// response scoreboard, plus hand-written reset sequences.
module tb_decoder_sched;

  localparam int unsigned TIMEOUT     = 32;
  localparam int unsigned DEC_RST_CYC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [13:0] req0_rstring, req1_rstring, dec_rstring;
  logic [2:0]  req0_size, req1_size, dec_size;
  logic        dec_rst, dec_done;
  logic [6:0]  dec_dstring, resp_dstring;
  logic        resp_valid, resp_ready, resp_id, resp_err, busy;

  always #5 clk = ~clk;

  decoder_sched #(.TIMEOUT(TIMEOUT), .DEC_RST_CYC(DEC_RST_CYC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_rstring(req0_rstring), .req0_size(req0_size),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_rstring(req1_rstring), .req1_size(req1_size),
    .dec_rst(dec_rst), .dec_rstring(dec_rstring), .dec_size(dec_size),
    .dec_dstring(dec_dstring), .dec_done(dec_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_dstring(resp_dstring), .resp_err(resp_err), .busy(busy)
  );

  // Decoder model: done pulses model_delay cycles after dec_rst drops (negative = never)
  int         model_delay = -1;
  logic [6:0] model_ds    = '0;
  int         mcnt        = 0;
  always @(posedge clk) begin
    if (dec_rst) mcnt <= 0;
    else         mcnt <= mcnt + 1;
  end
  assign dec_done    = (model_delay >= 0) && !dec_rst && (mcnt == model_delay);
  assign dec_dstring = model_ds;

  typedef struct {
    logic        v0, v1;
    logic [13:0] rs0, rs1;
    logic [2:0]  sz0, sz1;
    int          delay;
    logic [6:0]  ds;
    logic        hold;
    int          bp;
    logic        exp_id;
    logic        exp_err;
    logic [6:0]  exp_ds;
    int          exp_lat;
    int          exp_rstc;
  } vec_t;

  typedef struct packed {
    logic       id;
    logic       err;
    logic [6:0] ds;
  } resp_t;

  resp_t sb[$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v0, input logic v1, input logic [13:0] rs0,
                              input logic [13:0] rs1, input logic [2:0] sz0,
                              input logic [2:0] sz1, input int delay, input logic [6:0] ds,
                              input logic hold, input int bp, input logic exp_id,
                              input logic exp_err, input logic [6:0] exp_ds,
                              input int exp_lat, input int exp_rstc);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.rs0 = rs0; v.rs1 = rs1; v.sz0 = sz0; v.sz1 = sz1;
    v.delay = delay; v.ds = ds; v.hold = hold; v.bp = bp; v.exp_id = exp_id;
    v.exp_err = exp_err; v.exp_ds = exp_ds; v.exp_lat = exp_lat; v.exp_rstc = exp_rstc;
    return v;
  endfunction

  // Runs one job; entered and left just after a falling edge with the DUT in IDLE
  task automatic run_vec(input vec_t v, input int idx);
    resp_t       e, got;
    int          lat, rstc;
    bit          seen_rdy, stable;
    logic [13:0] grs;
    logic [2:0]  gsz;
    logic        s_id, s_err;
    logic [6:0]  s_ds;
    model_delay  = v.delay;
    model_ds     = v.ds;
    req0_valid   = v.v0;
    req1_valid   = v.v1;
    req0_rstring = v.rs0;
    req1_rstring = v.rs1;
    req0_size    = v.sz0;
    req1_size    = v.sz1;
    #1;
    chk($sformatf("v%0d req0_ready", idx), req0_ready, v.exp_id == 1'b0);
    chk($sformatf("v%0d req1_ready", idx), req1_ready, v.exp_id == 1'b1);
    e.id = v.exp_id; e.err = v.exp_err; e.ds = v.exp_ds;
    sb.push_back(e);
    grs = v.exp_id ? v.rs1 : v.rs0;
    gsz = v.exp_id ? v.sz1 : v.sz0;
    lat = 0; rstc = 0; seen_rdy = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (!v.hold) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
      if (k == 1) begin
        chk($sformatf("v%0d dec_rstring", idx), dec_rstring, grs);
        chk($sformatf("v%0d dec_size", idx), dec_size, gsz);
      end
      if (dec_rst) rstc++;
      if (req0_ready || req1_ready) seen_rdy = 1;
      if (resp_valid) begin lat = k; break; end
    end
    chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d dec_rst cycles", idx), rstc, v.exp_rstc);
    chk($sformatf("v%0d ready while busy", idx), seen_rdy, 1'b0);
    resp_ready = 1'b0;
    if (v.bp > 0) begin
      stable = 1; s_id = resp_id; s_err = resp_err; s_ds = resp_dstring;
      req0_valid = 1'b1;
      for (int b = 0; b < v.bp; b++) begin
        @(negedge clk); #1;
        if (!resp_valid || resp_id !== s_id || resp_err !== s_err || resp_dstring !== s_ds ||
            req0_ready || req1_ready) stable = 0;
      end
      chk($sformatf("v%0d backpressure stable", idx), stable, 1'b1);
    end
    if (sb.size() == 0) begin
      chk($sformatf("v%0d scoreboard empty", idx), 0, 1);
    end else begin
      got = sb.pop_front();
      chk($sformatf("v%0d resp_id", idx), resp_id, got.id);
      chk($sformatf("v%0d resp_err", idx), resp_err, got.err);
      chk($sformatf("v%0d resp_dstring", idx), resp_dstring, got.ds);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk($sformatf("v%0d resp_valid after hs", idx), resp_valid, 1'b0);
    chk($sformatf("v%0d busy after hs", idx), busy, 1'b0);
    if (!v.hold) begin req0_valid = 1'b0; req1_valid = 1'b0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[9];

  initial begin
    vecs[0] = mk(1, 0, 14'b11111001101011, 14'h0000, 3'b011, 3'b000, 3, 7'b1010101, 0, 0,
                 0, 0, 7'b1010101, 6, DEC_RST_CYC);
    vecs[1] = mk(0, 1, 14'h0000, 14'h2abc, 3'b000, 3'b101, 3, 7'h55, 0, 0,
                 1, 1, 7'h00, 1, 0);
    vecs[2] = mk(1, 1, 14'h0123, 14'h3210, 3'b000, 3'b001, 0, 7'h11, 1, 0,
                 0, 0, 7'h11, 3, DEC_RST_CYC);
    vecs[3] = mk(1, 1, 14'h0123, 14'h3210, 3'b000, 3'b001, 5, 7'h22, 1, 0,
                 1, 0, 7'h22, 8, DEC_RST_CYC);
    vecs[4] = mk(1, 1, 14'h0123, 14'h3210, 3'b000, 3'b001, 1, 7'h33, 1, 0,
                 0, 0, 7'h33, 4, DEC_RST_CYC);
    vecs[5] = mk(1, 1, 14'h0123, 14'h3210, 3'b000, 3'b001, 2, 7'h44, 0, 0,
                 1, 0, 7'h44, 5, DEC_RST_CYC);
    vecs[6] = mk(1, 0, 14'h1555, 14'h0000, 3'b010, 3'b000, -1, 7'h7f, 0, 0,
                 0, 1, 7'h00, 34, DEC_RST_CYC);
    vecs[7] = mk(0, 1, 14'h0000, 14'h0f0f, 3'b000, 3'b001, 4, 7'h5a, 0, 10,
                 1, 0, 7'h5a, 7, DEC_RST_CYC);
    vecs[8] = mk(1, 0, 14'h2468, 14'h0000, 3'b000, 3'b000, 31, 7'h0c, 0, 0,
                 0, 0, 7'h0c, 34, DEC_RST_CYC);

    // Reset with both requesters asserting valid: everything must hold its reset value
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b0;
    req0_rstring = 14'h3fff; req1_rstring = 14'h3fff; req0_size = 3'b011; req1_size = 3'b011;
    #1 rst = 1'b1;
    #1;
    chk("rst dec_rst", dec_rst, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst resp_valid", resp_valid, 1'b0);
    chk("rst resp_id", resp_id, 1'b0);
    chk("rst resp_dstring", resp_dstring, 7'h00);
    chk("rst resp_err", resp_err, 1'b0);
    chk("rst dec_rstring", dec_rstring, 14'h0000);
    chk("rst dec_size", dec_size, 3'b000);
    chk("rst req0_ready", req0_ready, 1'b0);
    chk("rst req1_ready", req1_ready, 1'b0);
    repeat (2) @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("idle dec_rst", dec_rst, 1'b0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Abort a job from requester 0 mid-RUN with an asynchronous reset
    model_delay = -1;
    req0_valid = 1'b1; req0_rstring = 14'h2222; req0_size = 3'b010; req1_valid = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort dec_rst", dec_rst, 1'b1);
    chk("abort busy", busy, 1'b0);
    chk("abort resp_valid", resp_valid, 1'b0);
    chk("abort dec_rstring", dec_rstring, 14'h0000);
    chk("abort req0_ready", req0_ready, 1'b0);
    chk("abort req1_ready", req1_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(mk(1, 1, 14'h1111, 14'h2222, 3'b010, 3'b011, 1, 7'h66, 0, 0,
               0, 0, 7'h66, 4, DEC_RST_CYC), 9);
    chk("scoreboard drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_sched.md
Name: decoder_sched

Overview:
- Two-requester round-robin scheduler that shares one instance of the team's Hamming `decoder` block (rstring/size in, dstring/done out).
- Each job runs as follows:
  - accept a codeword job from one requester;
  - restart the decoder with that job;
  - wait for `done`, with a watchdog on the wait;
  - return the decoded string, tagged with the requester ID, on a single response channel.
- Sits between the link-layer receive buffers and the shared decoder.

Parameters:
- TIMEOUT, 32, max cycles spent in RUN waiting for dec_done before the job is aborted with an error (2..255).
- DEC_RST_CYC, 1, number of cycles dec_rst is held high at job start (1..4).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- req0_valid  in  1  requester 0 has a job
- req0_ready  out  1  requester 0 job accepted this cycle
- req0_rstring  in  14  requester 0 received codeword
- req0_size  in  3  requester 0 size code
- req1_valid, req1_ready, req1_rstring, req1_size: same as requester 0, for requester 1
- dec_rst  out  1  reset/restart to the shared decoder
- dec_rstring  out  14  codeword driven to the decoder
- dec_size  out  3  size code driven to the decoder
- dec_dstring  in  7  decoder result
- dec_done  in  1  decoder finished
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes response
- resp_id  out  1  requester that owns the response
- resp_dstring  out  7  decoded string (0 on error)
- resp_err  out  1  1 = timeout or illegal size
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate) clears all state:
  - state = IDLE, last_grant = 1 (so requester 0 wins first);
  - cnt = 0;
  - dec_rst = 1 while rst is asserted;
  - dec_rstring = 0, dec_size = 0;
  - resp_valid = 0, resp_id = 0, resp_dstring = 0, resp_err = 0;
  - req*_ready = 0, busy = 0.
- Reset mid-job aborts the job; no response is produced.
- States: IDLE, LOAD, RUN, RESP.
- IDLE:
  - reqN_ready is combinational and is 1 only for the granted requester.
  - Grant rule:
    - if exactly one valid, grant it;
    - if both valid, grant !last_grant.
  - A transfer (valid & ready) does all of the following:
    - latches rstring/size into dec_rstring/dec_size;
    - sets resp_id = grant and last_grant = grant.
  - Next state after a transfer:
    - size code 0..3 → LOAD;
    - size code 4..7 → RESP with resp_err = 1 and resp_dstring = 0; the decoder is not touched.
  - No valid: stay in IDLE.
- LOAD:
  - dec_rst = 1 for DEC_RST_CYC cycles (counted by cnt), then → RUN with cnt = 0.
  - dec_done is ignored in LOAD.
- RUN:
  - dec_rst = 0; dec_rstring and dec_size are held stable.
  - Each cycle cnt increments.
  - dec_done = 1: latch resp_dstring = dec_dstring, resp_err = 0, → RESP.
  - cnt reaches TIMEOUT-1 without dec_done: resp_dstring = 0, resp_err = 1, → RESP.
  - If dec_done arrives in the same cycle as the timeout, dec_done wins (no error).
- RESP:
  - resp_valid = 1; resp_id, resp_dstring and resp_err are held stable.
  - On resp_valid & resp_ready → IDLE next cycle; resp_valid deasserts then.
  - No new job is accepted in the same cycle as a response handshake.
  - req*_ready = 0 in every state except IDLE.
- Latency, with acceptance at cycle T:
  - dec_rst is high for cycles T+1 .. T+DEC_RST_CYC;
  - RUN starts at T+DEC_RST_CYC+1;
  - resp_valid rises the cycle after dec_done is sampled.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…
- dec_rstring and dec_size hold the last job's values in IDLE; they are not cleared.

Test Plan:
- Single job: req0 rstring = 14'b11111001101011, size = 3'b011; decoder model asserts done 3 cycles into RUN with dstring = 7'b1010101 → req0_ready for 1 cycle; dec_rst high exactly 1 cycle; resp_valid with resp_id = 0, resp_dstring = 7'b1010101, resp_err = 0; busy drops after resp_ready.
- Contention: req0 and req1 both valid continuously for 4 jobs → grant order 0,1,0,1; each resp_id matches its job; the losing requester's ready stays 0 until it is granted.
- Timeout: decoder model never asserts done → resp_err = 1, resp_dstring = 0, and resp_valid rises exactly TIMEOUT cycles after RUN entry; with TIMEOUT = 32, resp_valid rises 34 cycles after acceptance.
- Illegal size: req1 size = 3'b101 → RESP the next cycle with resp_err = 1; dec_rst is never asserted.
- Backpressure and async reset: hold resp_ready = 0 for 10 cycles → resp_* stable and no new ready, then a clean handshake. Assert rst asynchronously mid-RUN → outputs immediately take reset values; the next job, with both requesters valid, is granted to requester 0.
